// File: rtl/sdemux.sv
// sdemux: parallel-to-serial unpacker for the FFT datapath.
// Takes one packed word of LANES complex samples and emits the samples one
// per cycle, lane 0 (LSBs of data_in) first. An active word (ACT) is being
// drained while a second word can wait in a pending slot (PEND). This lets
// the next word be ready at the last lane, so output runs without gaps.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   flush       synchronous drop of all buffered words (word_cnt is kept)
//   in_valid    data_in holds a packed word
//   in_ready    a word can be accepted (registered, only depends on pend_v)
//   data_in     packed word, lane 0 in the LSBs
//   out_valid   data_out holds a sample
//   out_ready   downstream takes data_out this cycle
//   data_out    current sample
//   out_lane    lane index of data_out
//   out_last    data_out is the final lane of its word
//   word_cnt    number of fully drained words, wraps at 2^16
module sdemux #(
    parameter int SAMPLE_W = 34,
    parameter int LANES    = 4,
    localparam int LW      = $clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*SAMPLE_W-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAMPLE_W-1:0]       data_out,
    output logic [LW-1:0]             out_lane,
    output logic                      out_last,
    output logic [15:0]               word_cnt
);

    logic [LANES-1:0][SAMPLE_W-1:0] act;
    logic [LANES-1:0][SAMPLE_W-1:0] pend;
    logic                           act_v;
    logic                           pend_v;
    logic [LW-1:0]                  lane;

    logic accept;
    logic pop;
    logic pop_last;

    // in_ready is a pure function of registered state so upstream never
    // sees a combinational path from out_ready.
    assign in_ready  = !pend_v;
    assign accept    = in_valid && in_ready;
    assign out_valid = act_v;
    assign pop       = act_v && out_ready;
    assign out_last  = act_v && (lane == LW'(LANES - 1));
    assign pop_last  = pop && out_last;
    assign data_out  = act[lane];
    assign out_lane  = lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act      <= '0;
            pend     <= '0;
            act_v    <= 1'b0;
            pend_v   <= 1'b0;
            lane     <= '0;
            word_cnt <= '0;
        end else if (flush) begin
            // Flush overrides any handshake happening in the same cycle.
            act_v  <= 1'b0;
            pend_v <= 1'b0;
            lane   <= '0;
        end else if (pop_last) begin
            lane     <= '0;
            word_cnt <= word_cnt + 16'd1;
            if (pend_v) begin
                // accept cannot happen here because in_ready is low.
                act    <= pend;
                pend_v <= 1'b0;
            end else if (accept) begin
                act <= data_in;
            end else begin
                act_v <= 1'b0;
            end
        end else begin
            if (pop)
                lane <= lane + LW'(1);
            if (accept) begin
                if (!act_v) begin
                    act   <= data_in;
                    act_v <= 1'b1;
                    lane  <= '0;
                end else begin
                    pend   <= data_in;
                    pend_v <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdemux.sv
// Testbench for sdemux. A sample queue models the buffered words. Each
// accepted word adds its lanes to the back of the queue, and each pop must
// match the front. Two predictions come from the queue size:
// out_valid = queue non-empty, and in_ready = at most one word's worth of
// samples still buffered.
module tb_sdemux;

    localparam int SW = 34;
    localparam int LN = 4;
    localparam int DW = SW * LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] data_out;
    logic [1:0]    out_lane;
    logic          out_last;
    logic [15:0]   word_cnt;

    sdemux #(.SAMPLE_W(SW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_lane(out_lane), .out_last(out_last), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [SW-1:0] d;
        int            lane;
    } smp_t;

    smp_t q[$];
    int   wc_m = 0;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          ov;
        logic [1:0]    lane;
        logic [SW-1:0] d;
        logic          last;
        logic          ir;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkword(input int base);
        logic [DW-1:0] w;
        w = '0;
        for (int l = 0; l < LN; l++)
            w[l*SW +: SW] = SW'(base + l);
        return w;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int l = 0; l < LN; l++)
            w[l*SW +: SW] = {$urandom(), $urandom()};
        return w;
    endfunction

    // Check outputs against the model, then apply this cycle's handshake.
    task automatic model_step();
        chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
        chk("in_ready", DW'(in_ready), DW'(q.size() <= LN));
        chk("word_cnt", DW'(word_cnt), DW'(wc_m[15:0]));
        if (q.size() > 0) begin
            chk("data_out", DW'(data_out), DW'(q[0].d));
            chk("out_lane", DW'(out_lane), DW'(q[0].lane));
            chk("out_last", DW'(out_last), DW'(q[0].lane == LN - 1));
        end
        if (flush) begin
            q.delete();
            return;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                if (q[0].lane == LN - 1) wc_m++;
                void'(q.pop_front());
            end
        end
        if (in_valid && in_ready)
            for (int l = 0; l < LN; l++)
                q.push_back('{d: data_in[l*SW +: SW], lane: l});
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        half();
        model_step();
        fin();
    endtask

    initial begin
        int acc_t[8];
        int na, pops, bubbles, gaps, frz, started, wc_save;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_data_out", DW'(data_out), 0);
        chk("rst_out_lane", DW'(out_lane), 0);
        chk("rst_out_last", DW'(out_last), 0);
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_word_cnt", DW'(word_cnt), 0);
        rst = 1'b0;
        fin();

        // Single word: lanes 0..3 hold 0..3.
        tbl[0] = '{iv:1, ordy:0, ov:0, lane:0, d:0, last:0, ir:1};
        for (int i = 1; i <= 4; i++)
            tbl[i] = '{iv:0, ordy:1, ov:1, lane:2'(i-1), d:SW'(i-1), last:(i == 4), ir:1};
        tbl[5] = '{iv:0, ordy:1, ov:0, lane:0, d:0, last:0, ir:1};
        data_in = mkword(0);
        for (int i = 0; i < 6; i++) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            half();
            chk($sformatf("tbl%0d_ov", i), DW'(out_valid), DW'(tbl[i].ov));
            chk($sformatf("tbl%0d_ir", i), DW'(in_ready), DW'(tbl[i].ir));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_lane", i), DW'(out_lane), DW'(tbl[i].lane));
                chk($sformatf("tbl%0d_data", i), DW'(data_out), DW'(tbl[i].d));
                chk($sformatf("tbl%0d_last", i), DW'(out_last), DW'(tbl[i].last));
            end
            model_step();
            fin();
        end
        chk("single_word_cnt", DW'(word_cnt), 1);

        // Back-to-back: 8 words, no bubble, one accept every 4 cycles.
        na = 0; pops = 0; bubbles = 0; started = 0;
        in_valid = 1'b1; out_ready = 1'b1; data_in = mkword(16);
        for (int c = 0; c < 60 && pops < 32; c++) begin
            logic acc;
            half();
            acc = in_valid && in_ready;
            if (out_valid) started = 1;
            else if (started) bubbles++;
            if (out_valid && out_ready) pops++;
            model_step();
            if (acc && na < 8) begin
                acc_t[na] = c;
                na++;
            end
            fin();
            if (acc) data_in = mkword(16 * (na + 1));
            if (na == 8) in_valid = 1'b0;
        end
        gaps = 0;
        for (int i = 2; i < 8; i++)
            if (acc_t[i] - acc_t[i-1] != 4) gaps++;
        chk("b2b_pops", DW'(pops), 32);
        chk("b2b_accepts", DW'(na), 8);
        chk("b2b_bubbles", DW'(bubbles), 0);
        chk("b2b_accept_gaps", DW'(gaps), 0);

        // Backpressure: two words buffered, output stalled for 10 cycles.
        out_ready = 1'b0; in_valid = 1'b1; na = 0; data_in = mkword(200);
        for (int c = 0; c < 10 && na < 2; c++) begin
            logic acc;
            half();
            acc = in_valid && in_ready;
            model_step();
            fin();
            if (acc) begin
                na++;
                data_in = mkword(200 + 16 * na);
            end
        end
        chk("bp_loaded", DW'(na), 2);
        frz = 0;
        for (int c = 0; c < 10; c++) begin
            half();
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_lane !== 2'd0 ||
                data_out !== SW'(200))
                frz++;
            model_step();
            fin();
        end
        chk("bp_frozen", DW'(frz), 0);
        in_valid = 1'b0; out_ready = 1'b1; pops = 0;
        for (int c = 0; c < 20 && (c == 0 || out_valid); c++) begin
            half();
            if (out_valid && out_ready) pops++;
            model_step();
            fin();
        end
        chk("bp_drain_pops", DW'(pops), 8);

        // Flush with both slots full, ACT at lane 2.
        out_ready = 1'b0; in_valid = 1'b1;
        data_in = mkword(300); cyc();
        data_in = mkword(316); cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        half();
        chk("fl_pre_lane", DW'(out_lane), 2);
        chk("fl_pre_ready", DW'(in_ready), 0);
        model_step();
        fin();
        wc_save = wc_m;
        flush = 1'b1; in_valid = 1'b1; data_in = mkword(400);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        half();
        chk("fl_out_valid", DW'(out_valid), 0);
        chk("fl_in_ready", DW'(in_ready), 1);
        chk("fl_word_cnt", DW'(word_cnt), DW'(wc_save[15:0]));
        model_step();
        fin();

        // Asynchronous reset in the middle of a word.
        in_valid = 1'b1; out_ready = 1'b1; data_in = mkword(500);
        cyc();
        in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("arst_out_valid", DW'(out_valid), 0);
        chk("arst_in_ready", DW'(in_ready), 1);
        chk("arst_word_cnt", DW'(word_cnt), 0);
        chk("arst_out_lane", DW'(out_lane), 0);
        q.delete(); wc_m = 0;
        fin();
        rst = 1'b0;

        // Random traffic: 1000 words with random stalls on both sides.
        na = 0;
        for (int c = 0; c < 30000 && (na < 1000 || q.size() > 0); c++) begin
            logic acc;
            in_valid  = (na < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            data_in   = rnd_word();
            half();
            acc = in_valid && in_ready;
            model_step();
            fin();
            if (acc) na++;
        end
        half();
        chk("rnd_accepted", DW'(na), 1000);
        chk("rnd_drained", DW'(q.size()), 0);
        chk("rnd_word_cnt", DW'(word_cnt), 1000);
        chk("rnd_out_valid", DW'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
